// File: rtl/req_encoder_pkg.sv
// req_encoder_pkg: shared sizes and round-robin pointer helper for req_encoder
package req_encoder_pkg;
  localparam int N_REQ_DEFAULT = 8;
  localparam int CODE_W_DEFAULT = 3;
  function automatic int rr_next(input int idx, input int n = N_REQ_DEFAULT);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/req_encoder_rr_picker.sv
// req_encoder_rr_picker: first set bit of eligible searching upward from ptr with wrap
module req_encoder_rr_picker
  import req_encoder_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  localparam int CODE_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  eligible,
  input  logic [CODE_W-1:0] ptr,
  output logic [CODE_W-1:0] pick,
  output logic              any
);
  logic [CODE_W-1:0] idx;
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + CODE_W'(k);
      if (eligible[idx]) pick = idx;
    end
    any = |eligible;
  end
endmodule

// File: rtl/req_encoder.sv
// req_encoder: round-robin request encoder with valid/ready output; REQ_ENCODER_OVERFLOW_EN enables sticky overflow
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  localparam int CODE_W = $clog2(N_REQ)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_REQ-1:0]  Req_in,
  input  logic              Ready_in,
  output logic              Valid_out,
  output logic [CODE_W-1:0] Code_out,
  output logic              Overflow_out
);
  logic [N_REQ-1:0] pending_q, pending_d, eligible;
  logic [CODE_W-1:0] ptr_q, ptr_d, code_q, code_d, pick;
  logic valid_q, valid_d, any, load;
  req_encoder_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .eligible(eligible),
    .ptr(ptr_q),
    .pick(pick),
    .any(any)
  );
  always_comb begin
    eligible = pending_q | Req_in;
    load = !valid_q || Ready_in;
    pending_d = eligible;
    ptr_d = ptr_q;
    code_d = code_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = any;
      if (any) begin
        code_d = pick;
        pending_d = eligible & ~(N_REQ'(1) << pick);
        ptr_d = CODE_W'(rr_next(int'(pick), N_REQ));
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pending_q <= '0;
      ptr_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q <= ptr_d;
      code_q <= code_d;
      valid_q <= valid_d;
    end
  end
  assign Valid_out = valid_q;
  assign Code_out = code_q;
`ifdef REQ_ENCODER_OVERFLOW_EN
  logic ovf_q, ovf_d;
  always_comb ovf_d = ovf_q || |(Req_in & pending_q);
  always_ff @(posedge Clk) begin
    if (Rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign Overflow_out = ovf_q;
`else
  assign Overflow_out = 1'b0;
`endif
endmodule

// File: tb/tb_req_encoder.sv
// tb_req_encoder: directed plus random stimulus checked by a set-based model and a grant scoreboard
module tb_req_encoder;
  localparam int N = 8;
`ifdef REQ_ENCODER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic [N-1:0] Req_in = '1;
  logic Ready_in = 1'b1;
  logic Valid_out;
  logic [2:0] Code_out;
  logic Overflow_out;
  int tests = 0;
  int fails = 0;
  bit m_pend [N];
  int m_ptr = 0;
  bit m_valid = 1'b0;
  int m_code = 0;
  bit m_ovf = 1'b0;
  int exp_q [$];
  req_encoder dut (
    .Clk(Clk),
    .Rst(Rst),
    .Req_in(Req_in),
    .Ready_in(Ready_in),
    .Valid_out(Valid_out),
    .Code_out(Code_out),
    .Overflow_out(Overflow_out)
  );
  always #5 Clk = ~Clk;
  // Reference: a set of outstanding indices served by scanning from the pointer
  always @(posedge Clk) begin : model
    int pick;
    if (Rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0;
      m_valid = 1'b0;
      m_code = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (OVF_EN && Req_in[i] && m_pend[i]) m_ovf = 1'b1;
        if (Req_in[i]) m_pend[i] = 1'b1;
      end
      if (!m_valid || Ready_in) begin
        pick = -1;
        for (int k = 0; k < N; k++)
          if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        if (pick < 0) m_valid = 1'b0;
        else begin
          m_pend[pick] = 1'b0;
          m_ptr = (pick + 1) % N;
          m_valid = 1'b1;
          m_code = pick;
          exp_q.push_back(pick);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask
  always @(negedge Clk) begin : monitor
    int exp_code;
    chk("valid", int'(Valid_out), int'(m_valid));
    chk("overflow", int'(Overflow_out), int'(m_ovf));
    if (m_valid) chk("code_state", int'(Code_out), m_code);
    if (!Rst && Valid_out && Ready_in) begin
      if (exp_q.size() == 0) chk("unexpected_grant", int'(Code_out), -1);
      else begin
        exp_code = exp_q.pop_front();
        chk("grant", int'(Code_out), exp_code);
      end
    end
  end
  task automatic cyc(input logic [N-1:0] r, input logic rdy, input int n = 1);
    Req_in = r;
    Ready_in = rdy;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc('0, 1'b1, 2);
    cyc(8'h04, 1'b1);
    cyc('0, 1'b1, 3);
    cyc(8'h81, 1'b1);
    cyc('0, 1'b1, 3);
    cyc(8'h81, 1'b1);
    cyc('0, 1'b1, 3);
    cyc(8'h10, 1'b0);
    cyc(8'h02, 1'b0);
    cyc('0, 1'b0, 5);
    cyc('0, 1'b1, 3);
    cyc(8'hFF, 1'b1, 16);
    cyc('0, 1'b1, 10);
    cyc(8'h08, 1'b0, 3);
    cyc('0, 1'b0, 3);
    cyc('0, 1'b1, 4);
    for (int i = 0; i < 400; i++) begin
      Rst = ($urandom_range(63) == 0);
      cyc(($urandom_range(3) == 0) ? N'($urandom) : '0, 1'($urandom_range(3) != 0));
    end
    Rst = 1'b0;
    cyc('0, 1'b1, 12);
    chk("drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/req_encoder.md
# req_encoder

- Sequential round-robin request encoder.
- Collects up to 8 single-cycle request strobes, holds them as pending, and issues them one at a time as 3-bit binary codes over a valid/ready handshake.
- Sits directly upstream of the team's 3-to-8 decoder: Code_out drives the decoder's Data_in, which regenerates the one-hot select for the granted request line.

## Interface
- N_REQ, 8: number of request lines; power of two, 2..256.
- CODE_W, $clog2(N_REQ) = 3: width of Code_out; derived, not overridden.
- Clk  input  1  rising-edge clock, single clock domain.
- Rst  input  1  reset, synchronous, active-high.
- Req_in  input  N_REQ  request strobes; bit i high for a cycle means request i.
- Ready_in  input  1  consumer accepts Code_out this cycle.
- Valid_out  output  1  Code_out holds a valid grant.
- Code_out  output  CODE_W  binary index of the granted request.
- Overflow_out  output  1  sticky flag: a request merged into an already-pending one.

## Operation
- State:
  - pending[N_REQ-1:0]
  - round-robin pointer Ptr[CODE_W-1:0]
  - output register (Valid_q, Code_q), driving Valid_out and Code_out directly
  - Overflow_q
- eligible = pending | Req_in.
- load = !Valid_q || Ready_in. This is the output slot being empty or being drained this cycle.
- pick = first set bit of eligible, searching upward from Ptr and wrapping from N_REQ-1 to 0.
- On each rising edge, Rst low:
  - If load and eligible != 0:
    - Code_q <= pick
    - Valid_q <= 1
    - pending <= eligible with bit pick cleared
    - Ptr <= pick+1, wrapping modulo N_REQ
  - If load and eligible == 0:
    - Valid_q <= 0
    - pending unchanged (all zero)
  - If not load:
    - Valid_q and Code_q held
    - pending <= eligible
- Transfer occurs at an edge where Valid_out && Ready_in.
- Code_out never changes while Valid_out=1 and Ready_in=0.
- Multiple Req_in bits in one cycle are all captured and served in round-robin order.
- A request for the index currently held in Code_q sets its pending bit again and is served again later. It is not an overflow.
- Repeat requests for an already-pending index merge: one grant results.
- Ptr changes only on a load that issues a grant.

## Timing
- Reset values:
  - Valid_out=0
  - Code_out=0
  - Overflow_out=0
  - pending=0
  - Ptr=0
- Reset mid-operation discards all pending and held grants on that edge.
- Req_in asserted before edge N with an empty output slot gives Valid_out=1 after edge N. Latency is 1 cycle.
- Throughput: one grant per cycle while Ready_in stays high and eligible != 0.
- A grant accepted at edge N is replaced in the same edge by the next pick, or Valid_out drops. There are no bubble cycles.
- Ready_in is ignored while Valid_out=0.

## Configuration
- REQ_ENCODER_OVERFLOW_EN defined:
  - Overflow_q <= 1 on any edge where Req_in[i] & pending[i] for some i.
  - Cleared only by Rst.
- REQ_ENCODER_OVERFLOW_EN undefined:
  - No detection logic is built.
  - Overflow_out is tied to 0; the port remains for bench compatibility.

## Structure
- Package req_encoder_pkg holds:
  - N_REQ_DEFAULT = 8
  - CODE_W_DEFAULT = 3
  - function rr_next(idx), returning (idx+1) mod N_REQ
- One combinational sub-module, rr_picker, computes pick and an any-set flag from eligible and Ptr.
- The top level holds all registers and handshake logic.

## Test plan
- Reset behaviour: assert Rst with Req_in=8'hFF -> Valid_out=0, Code_out=0 and Overflow_out=0 on every cycle of reset and the first cycle after.
- Single request: Req_in=8'h04 for one cycle, Ready_in=1 -> Valid_out=1 with Code_out=2 for one cycle, then Valid_out=0.
- Simultaneous requests: Req_in=8'h81 for one cycle, Ready_in=1 -> Code_out=0 then 7 on consecutive cycles. Then Req_in=8'h81 again -> 0 then 7 (Ptr wrapped to 0).
- Backpressure: Ready_in=0, Req_in=8'h10 then 8'h02 -> Code_out=4 held stable for 5 cycles. Raise Ready_in -> Code_out=1 on the next cycle, then Valid_out=0.
- Round-robin fairness: Ready_in=1, Req_in=8'hFF every cycle for 16 cycles -> Code_out sequence 0,1,...,7,0,...,7.
- Overflow: Ready_in=0, Req_in=8'h08 on three consecutive cycles:
  - With REQ_ENCODER_OVERFLOW_EN: Overflow_out=1 after the third edge and stays set.
  - Without the macro: Overflow_out stays 0.
  - In both builds, Code_out=3 is issued once now and once more after release.
